decoder_2x4: RTL and testbench

One-hot 2-to-4 line decoder with a registered output copy and an optional switching-activity (toggle) counter. The decode path is purely combinational; the registered side tracks output bit transitions per clock for the power-estimation datapath. It sits at the front of the power-estimation accelerator as both a reference logic block and an activity source.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/decoder_2x4_if.sv | 30 +++
 rtl/toggle_counter.sv | 45 ++++
 rtl/decoder_2x4.sv | 66 ++++++
 tb/tb_decoder_2x4.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths and helper functions for the 2-to-4 decoder slice.
//   DEC_IN_W / DEC_OUT_W : select and one-hot output widths.
//   dec_onehot()         : 1 << code; an X/Z code yields X so unknowns stay visible.
//   popcount4()          : number of set bits in a 4-bit vector.
package decoder_pkg;

  localparam int unsigned DEC_IN_W  = 2;
  localparam int unsigned DEC_OUT_W = 4;

  function automatic logic [DEC_OUT_W-1:0] dec_onehot(input logic [DEC_IN_W-1:0] code);
    return 4'b0001 << code;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/decoder_2x4_if.sv
// decoder_2x4_if: signal bundle between the decoder and its user.
//   in[1:0]           select code (master -> slave)
//   cnt_clr           synchronous toggle-counter clear (master -> slave)
//   out[3:0]          combinational one-hot decode (slave -> master)
//   out_q[3:0]        registered copy of out (slave -> master)
//   toggle_cnt[CNT_W] accumulated output bit transitions (slave -> master)
//   cnt_sat           toggle_cnt is all ones (slave -> master)
interface decoder_2x4_if #(
  parameter int unsigned CNT_W = 16
) ();
  import decoder_pkg::*;

  logic [DEC_IN_W-1:0]  in;
  logic                 cnt_clr;
  logic [DEC_OUT_W-1:0] out;
  logic [DEC_OUT_W-1:0] out_q;
  logic [CNT_W-1:0]     toggle_cnt;
  logic                 cnt_sat;

  modport master (
    output in, cnt_clr,
    input  out, out_q, toggle_cnt, cnt_sat
  );

  modport slave (
    input  in, cnt_clr,
    output out, out_q, toggle_cnt, cnt_sat
  );

endinterface

// File: rtl/toggle_counter.sv
// toggle_counter: saturating accumulator of per-cycle bit transitions.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : synchronous clear, wins over the increment
//   inc_i[2:0]   : transitions seen this cycle (0..4)
//   cnt_o[CNT_W] : accumulated count, sticks at all ones
//   sat_o        : cnt_o is all ones
// CNT_W must be at least 4.
module toggle_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [2:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    // One extra bit catches the carry so the add can clamp instead of wrapping.
    sum = {1'b0, cnt_q} + {{(CNT_W - 2){1'b0}}, inc_i};
    if (clr_i) begin
      cnt_d = '0;
    end else if (sum[CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = &cnt_q;

endmodule

// File: rtl/decoder_2x4.sv
// decoder_2x4: one-hot 2-to-4 decoder with a registered output copy and an
// optional switching-activity counter for the power-estimation datapath.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (out_q, toggle_cnt)
//   bus.in     : select code;             bus.out   : 1 << in, combinational
//   bus.out_q  : out registered once;     bus.cnt_clr : clear toggle counter
//   bus.toggle_cnt / bus.cnt_sat : accumulated transitions / counter saturated
// Build option: define DECODER_2X4_TOGGLE_CNT_EN to build the toggle counter;
// otherwise toggle_cnt and cnt_sat are tied low and cnt_clr is ignored.
module decoder_2x4
  import decoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  decoder_2x4_if.slave  bus
);

  logic [DEC_OUT_W-1:0] dec_out;
  logic [DEC_OUT_W-1:0] out_reg_q, out_reg_d;

  // Decode ignores clk and rst entirely.
  always_comb begin
    dec_out   = dec_onehot(bus.in);
    out_reg_d = dec_out;
  end

  assign bus.out   = dec_out;
  assign bus.out_q = out_reg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg_q <= '0;
    end else begin
      out_reg_q <= out_reg_d;
    end
  end

`ifdef DECODER_2X4_TOGGLE_CNT_EN
  logic [2:0] toggles;

  // Bits about to change at this edge; first edge after reset counts 1 since out_q is 0.
  always_comb begin
    toggles = popcount4(dec_out ^ out_reg_q);
  end

  toggle_counter #(
    .CNT_W (CNT_W)
  ) u_toggle_counter (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (bus.cnt_clr),
    .inc_i (toggles),
    .cnt_o (bus.toggle_cnt),
    .sat_o (bus.cnt_sat)
  );
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.toggle_cnt = {CNT_W{1'b0}};
  assign bus.cnt_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_2x4.sv
// tb_decoder_2x4: directed vectors for decoder_2x4 with a queue scoreboard.
// Stimulus pushes hand-computed expectations; the monitor pops and compares at
// each falling edge (or on demand for checks between edges).
module tb_decoder_2x4;

  logic clk;
  logic rst;

  decoder_2x4_if #(.CNT_W(16)) bus_a ();
  decoder_2x4_if #(.CNT_W(4))  bus_b ();

  decoder_2x4 #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  decoder_2x4 #(.CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          dut;
    logic [3:0]  out;
    logic [3:0]  q;
    logic [15:0] cnt;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  event chk_now;

  function automatic void push(input string n, input bit d, input logic [3:0] o,
                               input logic [3:0] q, input logic [15:0] c, input logic s);
    exp_t e;
`ifndef DECODER_2X4_TOGGLE_CNT_EN
    // Counter not built: it must read zero and never saturate.
    c = '0;
    s = 1'b0;
`endif
    e.name = n;
    e.dut  = d;
    e.out  = o;
    e.q    = q;
    e.cnt  = c;
    e.sat  = s;
    sb.push_back(e);
  endfunction

  task automatic check(input string n, input string field, input logic [15:0] act,
                       input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h (t=%0t)", n, field, act, want, $time);
    end
  endtask

  // Monitor: compare every pending expectation against the selected DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.dut) begin
          check(e.name, "out",   {12'b0, bus_a.out},   {12'b0, e.out});
          check(e.name, "out_q", {12'b0, bus_a.out_q}, {12'b0, e.q});
          check(e.name, "cnt",   bus_a.toggle_cnt,     e.cnt);
          check(e.name, "sat",   {15'b0, bus_a.cnt_sat}, {15'b0, e.sat});
        end else begin
          check(e.name, "out",   {12'b0, bus_b.out},   {12'b0, e.out});
          check(e.name, "out_q", {12'b0, bus_b.out_q}, {12'b0, e.q});
          check(e.name, "cnt",   {12'b0, bus_b.toggle_cnt}, e.cnt);
          check(e.name, "sat",   {15'b0, bus_b.cnt_sat}, {15'b0, e.sat});
        end
      end
    end
  end

  // Drive one cycle on dut_a just after the rising edge; expectations hold
  // until the next edge (out from the new code, out_q/cnt from the edge just past).
  task automatic step_a(input logic r, input logic [1:0] i, input logic c, input string n,
                        input logic [3:0] eo, input logic [3:0] eq, input logic [15:0] ec);
    @(posedge clk);
    #1;
    rst           = r;
    bus_a.in      = i;
    bus_a.cnt_clr = c;
    push(n, 1'b0, eo, eq, ec, 1'b0);
  endtask

  task automatic step_b(input logic [1:0] i, input string n, input logic [3:0] eo,
                        input logic [3:0] eq, input logic [15:0] ec, input logic es);
    @(posedge clk);
    #1;
    bus_b.in      = i;
    bus_b.cnt_clr = 1'b0;
    push(n, 1'b1, eo, eq, ec, es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned sat_exp [10];
    sat_exp = '{2, 4, 6, 8, 10, 12, 14, 15, 15, 15};

    rst           = 1'b1;
    bus_a.in      = 2'd0;
    bus_a.cnt_clr = 1'b0;
    bus_b.in      = 2'd0;
    bus_b.cnt_clr = 1'b0;

    // Decode sweep while held in reset: out follows in, registers stay clear.
    step_a(1'b1, 2'd0, 1'b0, "sweep00", 4'b0001, 4'b0000, 16'd0);
    step_a(1'b1, 2'd1, 1'b0, "sweep01", 4'b0010, 4'b0000, 16'd0);
    step_a(1'b1, 2'd2, 1'b0, "sweep10", 4'b0100, 4'b0000, 16'd0);
    step_a(1'b1, 2'd3, 1'b0, "sweep11", 4'b1000, 4'b0000, 16'd0);

    // 00,01,10,11,11,01,00: increments 1,2,2,2,0,2,2 -> 11.
    step_a(1'b0, 2'd0, 1'b0, "seq0",      4'b0001, 4'b0000, 16'd0);
    step_a(1'b0, 2'd1, 1'b0, "seq1",      4'b0010, 4'b0001, 16'd1);
    step_a(1'b0, 2'd2, 1'b0, "seq2",      4'b0100, 4'b0010, 16'd3);
    step_a(1'b0, 2'd3, 1'b0, "seq3",      4'b1000, 4'b0100, 16'd5);
    step_a(1'b0, 2'd3, 1'b0, "seq4",      4'b1000, 4'b1000, 16'd7);
    step_a(1'b0, 2'd1, 1'b0, "seq5",      4'b0010, 4'b1000, 16'd7);
    step_a(1'b0, 2'd0, 1'b0, "seq6",      4'b0001, 4'b0010, 16'd9);
    step_a(1'b0, 2'd0, 1'b0, "seq_total", 4'b0001, 4'b0001, 16'd11);

    // Clear on the same edge as a code change: count 0, not 2; out_q still moves.
    step_a(1'b0, 2'd2, 1'b1, "clr_edge",  4'b0100, 4'b0001, 16'd11);
    step_a(1'b0, 2'd2, 1'b0, "clr_after", 4'b0100, 4'b0100, 16'd0);
    step_a(1'b0, 2'd1, 1'b0, "post_clr",  4'b0010, 4'b0100, 16'd0);
    step_a(1'b0, 2'd3, 1'b0, "pre_rst",   4'b1000, 4'b0010, 16'd2);
    step_a(1'b0, 2'd0, 1'b0, "mid",       4'b0001, 4'b1000, 16'd4);

    // Asynchronous reset between edges clears registers at once.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    push("async_rst", 1'b0, 4'b0001, 4'b0000, 16'd0, 1'b0);
    -> chk_now;
    #1;
    bus_a.in = 2'd2;
    #1;
    push("rst_follow", 1'b0, 4'b0100, 4'b0000, 16'd0, 1'b0);
    -> chk_now;

    step_a(1'b1, 2'd2, 1'b0, "rst_hold",    4'b0100, 4'b0000, 16'd0);
    step_a(1'b0, 2'd1, 1'b0, "rst_release", 4'b0010, 4'b0000, 16'd0);
    step_a(1'b0, 2'd1, 1'b0, "resume",      4'b0010, 4'b0010, 16'd1);

    // CNT_W=4: clear, then alternate codes until the counter clamps at 15.
    @(posedge clk);
    #1;
    bus_b.in      = 2'd0;
    bus_b.cnt_clr = 1'b1;
    step_b(2'd1, "sat_start", 4'b0010, 4'b0001, 16'd0, 1'b0);
    for (int k = 2; k <= 11; k++) begin
      step_b(2'(k % 2), $sformatf("sat%0d", k),
             (k % 2 == 1) ? 4'b0010 : 4'b0001,
             (k % 2 == 1) ? 4'b0001 : 4'b0010,
             16'(sat_exp[k-2]), (sat_exp[k-2] == 15));
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
